// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit serializer.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SOP,
        DATA,
        EOP
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam int unsigned DEF_EOP_LEN = 2;

endpackage

// File: rtl/tx_byte_buf.sv
// One-entry holding register between the byte handshake and the shift register.
module tx_byte_buf (
    input  logic       clk,
    input  logic       rst_L,
    input  logic [7:0] data,
    input  logic       last,
    input  logic       push,
    input  logic       pop,
    output logic [7:0] hold_data,
    output logic       hold_last,
    output logic       hold_valid
);

    // push is only offered while empty and pop only while full, so they never coincide
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            hold_data  <= '0;
            hold_last  <= 1'b0;
            hold_valid <= 1'b0;
        end else if (push) begin
            hold_data  <= data;
            hold_last  <= last;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/usb_tx_serializer.sv
// Packet serializer: SOP sync pattern, payload bits LSB-first, then EOP request,
// holding the current bit whenever the downstream bit stuffer pauses.
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int unsigned EOP_LEN = DEF_EOP_LEN
) (
    input  logic       clk,
    input  logic       rst_L,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    input  logic       pause,
    output logic       outb,
    output logic       start,
    output logic       sending,
    output logic       se0,
    output logic       done,
    output logic       underrun
);

    localparam logic [1:0] EOP_LAST = 2'(EOP_LEN - 1);

    tx_state_t  state;
    tx_state_t  next_state;
    logic [2:0] bitcnt;
    logic [1:0] eopcnt;
    logic [7:0] shreg;
    logic       cur_last;

    logic [7:0] hold_data;
    logic       hold_last;
    logic       hold_valid;
    logic       push;
    logic       pop;
    logic       last_bit;
    logic       eop_end;

    assign byte_ready = ~hold_valid & (state != EOP);
    assign push       = byte_valid & byte_ready;
    assign last_bit   = (state == DATA) && (bitcnt == 3'd7) && !pause;
    assign eop_end    = (state == EOP) && (eopcnt == EOP_LAST) && !pause;
    assign pop        = ((state == SOP) && (bitcnt == 3'd7))
                      || (last_bit && !cur_last && hold_valid);

    tx_byte_buf u_buf (
        .clk       (clk),
        .rst_L     (rst_L),
        .data      (byte_in),
        .last      (byte_last),
        .push      (push),
        .pop       (pop),
        .hold_data (hold_data),
        .hold_last (hold_last),
        .hold_valid(hold_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (hold_valid) next_state = SOP;
            SOP:  if (bitcnt == 3'd7) next_state = DATA;
            DATA: begin
                if (last_bit) begin
                    if (cur_last || !hold_valid) next_state = EOP;
                    else                         next_state = DATA;
                end
            end
            EOP:  if (eop_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // bitcnt wraps 7 -> 0 on its own, which is exactly the reload value for the next byte
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            bitcnt   <= '0;
            eopcnt   <= '0;
            shreg    <= '0;
            cur_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bitcnt <= '0;
                    eopcnt <= '0;
                end
                SOP: begin
                    bitcnt <= bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        shreg    <= hold_data;
                        cur_last <= hold_last;
                    end
                end
                DATA: begin
                    eopcnt <= '0;
                    if (!pause) begin
                        bitcnt <= bitcnt + 3'd1;
                        if (pop) begin
                            shreg    <= hold_data;
                            cur_last <= hold_last;
                        end else begin
                            shreg <= {1'b0, shreg[7:1]};
                        end
                    end
                end
                EOP: begin
                    if (!pause) eopcnt <= eopcnt + 2'd1;
                end
                default: begin
                    bitcnt <= '0;
                    eopcnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        outb     = 1'b0;
        start    = 1'b0;
        sending  = 1'b0;
        se0      = 1'b0;
        done     = 1'b0;
        underrun = 1'b0;
        case (state)
            SOP: begin
                start   = 1'b1;
                sending = 1'b1;
                outb    = SYNC_BYTE[bitcnt];
            end
            DATA: begin
                sending  = 1'b1;
                outb     = shreg[0];
                underrun = last_bit && !cur_last && !hold_valid;
            end
            EOP: begin
                sending = 1'b1;
                se0     = !pause;
                done    = eop_end;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed plus randomized packets against a bit-sequence reference model,
// with an optional behavioural bit stuffer driving pause.
module tb_usb_tx_serializer;

    localparam int unsigned EOP_LEN = 2;

    logic       clk = 1'b0;
    logic       rst_L;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;
    logic       pause;
    logic       outb;
    logic       start;
    logic       sending;
    logic       se0;
    logic       done;
    logic       underrun;

    usb_tx_serializer #(.EOP_LEN(EOP_LEN)) dut (
        .clk       (clk),
        .rst_L     (rst_L),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_last (byte_last),
        .byte_ready(byte_ready),
        .pause     (pause),
        .outb      (outb),
        .start     (start),
        .sending   (sending),
        .se0       (se0),
        .done      (done),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic st;
        logic s0;
        logic und;
        logic dn;
        bit   data;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] pkt[$];
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Expected line events for every non-paused bit time of one packet
    task automatic build_exp(input int nbytes, input bit starve);
        exp_t       e;
        logic [7:0] b;
        expq.delete();
        for (int i = 0; i < 8; i++) begin
            e.b = (i == 7); e.st = 1'b1; e.s0 = 1'b0; e.und = 1'b0; e.dn = 1'b0; e.data = 1'b0;
            expq.push_back(e);
        end
        for (int k = 0; k < nbytes; k++) begin
            b = pkt[k];
            for (int j = 0; j < 8; j++) begin
                e.b = b[j]; e.st = 1'b0; e.s0 = 1'b0; e.dn = 1'b0; e.data = 1'b1;
                e.und = starve && (j == 7) && (k == nbytes - 1);
                expq.push_back(e);
            end
        end
        for (int i = 0; i < int'(EOP_LEN); i++) begin
            e.b = 1'b0; e.st = 1'b0; e.s0 = 1'b1; e.und = 1'b0; e.data = 1'b0;
            e.dn = (i == int'(EOP_LEN) - 1);
            expq.push_back(e);
        end
    endtask

    // mode 0: no pause, 1: bit stuffer after six 1s, 2: random pauses
    task automatic run_packet(input int mode, input bit starve, input int abort_bit);
        int   nsend, fed, cyc, paused, ones, dbits;
        bit   xfer, prev_xfer, started, finished, aborted, done_seen;
        exp_t e;
        nsend = starve ? 1 : pkt.size();
        fed = 0; cyc = 0; paused = 0; ones = 0; dbits = 0;
        xfer = 0; prev_xfer = 0; started = 0; finished = 0; aborted = 0; done_seen = 0;
        build_exp(nsend, starve);
        for (int t = 0; t < 400 && !finished; t++) begin
            @(posedge clk); #1;
            if (xfer) fed++;
            prev_xfer  = xfer;
            byte_valid = (fed < nsend);
            byte_in    = (fed < pkt.size()) ? pkt[fed] : 8'($urandom);
            byte_last  = (fed == pkt.size() - 1);
            if (mode == 1)      pause = (ones == 6);
            else if (mode == 2) pause = sending && !start && ($urandom_range(0, 3) == 0);
            else                pause = 1'b0;
            @(negedge clk);
            xfer = byte_valid && byte_ready;
            if (prev_xfer) chk("ready_after_xfer", byte_ready, 0);
            if (sending) begin
                started = 1;
                cyc++;
                if (pause && !start) begin
                    paused++;
                    ones = 0;
                    chk("se0_during_pause", se0, 0);
                    chk("done_during_pause", done, 0);
                    chk("underrun_during_pause", underrun, 0);
                end else if (expq.size() == 0) begin
                    chk("sending_after_eop", sending, 0);
                    finished = 1;
                end else begin
                    e = expq.pop_front();
                    chk("outb", outb, e.b);
                    chk("start", start, e.st);
                    chk("se0", se0, e.s0);
                    chk("underrun", underrun, e.und);
                    chk("done", done, e.dn);
                    if (!start) ones = outb ? ones + 1 : 0;
                    if (e.dn) begin
                        finished  = 1;
                        done_seen = 1;
                    end
                    if (e.data) begin
                        if (dbits == abort_bit) begin
                            rst_L = 1'b0; byte_valid = 1'b0; pause = 1'b0;
                            @(posedge clk); #1;
                            rst_L = 1'b1;
                            @(negedge clk);
                            chk("abort_sending", sending, 0);
                            chk("abort_ready", byte_ready, 1);
                            chk("abort_outb", outb, 0);
                            chk("abort_start", start, 0);
                            chk("abort_done", done, 0);
                            repeat (3) begin
                                @(negedge clk);
                                chk("abort_no_done", done, 0);
                                chk("abort_stays_idle", sending, 0);
                            end
                            aborted  = 1;
                            finished = 1;
                        end
                        dbits++;
                    end
                end
            end else begin
                chk("done_while_idle", done, 0);
                chk("underrun_while_idle", underrun, 0);
                if (started) begin
                    chk("sending_dropped", sending, 1);
                    finished = 1;
                end
            end
        end
        if (!aborted) begin
            chk("packet_done_seen", done_seen, 1);
            chk("cycle_count", cyc, 8 + 8 * nsend + EOP_LEN + paused);
            @(posedge clk); #1;
            byte_valid = 1'b0;
            pause      = 1'b0;
            @(negedge clk);
            chk("idle_after_done", sending, 0);
            chk("ready_after_done", byte_ready, 1);
            chk("no_done_after", done, 0);
        end
        pkt.delete();
        expq.delete();
        byte_valid = 1'b0;
        pause      = 1'b0;
    endtask

    initial begin
        int len;
        rst_L = 1'b0; byte_valid = 1'b0; byte_in = '0; byte_last = 1'b0; pause = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_byte_ready", byte_ready, 1);
        chk("rst_sending", sending, 0);
        chk("rst_outb", outb, 0);
        chk("rst_start", start, 0);
        chk("rst_se0", se0, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        @(posedge clk); #1;
        rst_L = 1'b1;

        pkt = '{8'hA5};               run_packet(0, 0, -1);
        pkt = '{8'h01, 8'h02, 8'h03}; run_packet(0, 0, -1);
        pkt = '{8'hFF};               run_packet(1, 0, -1);
        pkt = '{8'hFC};               run_packet(1, 0, -1);
        pkt = '{8'h5A, 8'hC3};        run_packet(0, 1, -1);
        pkt = '{8'h96, 8'h69};        run_packet(0, 0, 4);
        pkt = '{8'h3F, 8'hE7};        run_packet(1, 0, -1);

        for (int p = 0; p < 8; p++) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) pkt.push_back(8'($urandom));
            run_packet((p % 2 == 1) ? 2 : 1, 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
